// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execution unit behind the ALU control decoder.
// Single-cycle ops (add/sub/move/swap/and/or/compare/nop) finish in one
// cycle. Unsigned multiply (shift-add) and divide (restoring) iterate
// WIDTH times. Result outputs only change when an op reaches DONE.
// Optional feature macro: ALU_OVERFLOW_EN adds the `ovf` output
// (signed overflow for add/sub).
//
// state | meaning
// IDLE  | waiting for start; result outputs hold the last completed op
// RUN   | one multiply/divide iteration per clock
// DONE  | done pulse; result outputs are valid
module alu_exec_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             lt,
  output logic             div_by_zero,
`ifdef ALU_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             illegal_op
);

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_MULT = 4'b0011;
  localparam logic [3:0] OP_DIV  = 4'b0100;
  localparam logic [3:0] OP_MOVE = 4'b0101;
  localparam logic [3:0] OP_SWAP = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b1000;
  localparam logic [3:0] OP_CMP  = 4'b1001;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic [WIDTH-1:0] r_op;   // multiplicand (mult) or divisor (div)
  logic [WIDTH-1:0] r_hi;   // product high half / partial remainder
  logic [WIDTH-1:0] r_lo;   // multiplier bits / dividend becoming quotient
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_result_hi;
  logic             r_zero;
  logic             r_lt;
  logic             r_dbz;
  logic             r_ill;

  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_res_hi;
  logic             w_zero;
  logic             w_lt;
  logic             w_ill;
  logic [WIDTH-1:0] w_add;
  logic [WIDTH-1:0] w_sub;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;

`ifdef ALU_OVERFLOW_EN
  logic r_ovf;
  logic w_ovf;
  assign ovf = r_ovf;
`endif

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign result      = r_result;
  assign result_hi   = r_result_hi;
  assign zero        = r_zero;
  assign lt          = r_lt;
  assign div_by_zero = r_dbz;
  assign illegal_op  = r_ill;

  assign w_add = op_a + op_b;
  assign w_sub = op_a - op_b;

  // Single-cycle datapath, evaluated straight from the input operands
  always_comb begin
    w_res    = '0;
    w_res_hi = '0;
    w_lt     = 1'b0;
    w_ill    = 1'b0;
`ifdef ALU_OVERFLOW_EN
    w_ovf    = 1'b0;
`endif
    case (operation)
      OP_NOP:  w_res = '0;
      OP_ADD: begin
        w_res = w_add;
`ifdef ALU_OVERFLOW_EN
        w_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (w_add[WIDTH-1] != op_a[WIDTH-1]);
`endif
      end
      OP_SUB: begin
        w_res = w_sub;
`ifdef ALU_OVERFLOW_EN
        w_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (w_sub[WIDTH-1] != op_a[WIDTH-1]);
`endif
      end
      OP_MOVE: w_res = op_b;
      OP_SWAP: begin
        w_res    = op_b;
        w_res_hi = op_a;
      end
      OP_AND:  w_res = op_a & op_b;
      OP_OR:   w_res = op_a | op_b;
      OP_CMP:  w_lt  = ($signed(op_a) < $signed(op_b));
      OP_MULT, OP_DIV: w_res = '0;
      default: w_ill = 1'b1;
    endcase
    w_zero = (operation == OP_CMP) ? (op_a == op_b) : (w_res == '0);
  end

  // One iteration of shift-add multiply or restoring divide
  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_op} : '0);
    w_shift = {r_hi, r_lo[WIDTH-1]};
    w_diff  = w_shift[WIDTH-1:0] - r_op;
    if (r_is_div) begin
      if (w_shift >= {1'b0, r_op}) begin
        w_hi_nxt = w_diff;
        w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_hi_nxt = w_shift[WIDTH-1:0];
        w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_hi_nxt = w_sum[WIDTH:1];
      w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  // Control FSM; result outputs are only written on the way into DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_is_div    <= 1'b0;
      r_op        <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_zero      <= 1'b0;
      r_lt        <= 1'b0;
      r_dbz       <= 1'b0;
      r_ill       <= 1'b0;
`ifdef ALU_OVERFLOW_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (operation == OP_MULT) begin
              r_op     <= op_a;
              r_lo     <= op_b;
              r_hi     <= '0;
              r_is_div <= 1'b0;
              r_cnt    <= '0;
              r_state  <= S_RUN;
            end else if (operation == OP_DIV && op_b != '0) begin
              r_op     <= op_b;
              r_lo     <= op_a;
              r_hi     <= '0;
              r_is_div <= 1'b1;
              r_cnt    <= '0;
              r_state  <= S_RUN;
            end else if (operation == OP_DIV) begin
              r_result    <= '1;
              r_result_hi <= op_a;
              r_zero      <= 1'b0;
              r_lt        <= 1'b0;
              r_dbz       <= 1'b1;
              r_ill       <= 1'b0;
`ifdef ALU_OVERFLOW_EN
              r_ovf       <= 1'b0;
`endif
              r_state     <= S_DONE;
            end else begin
              r_result    <= w_res;
              r_result_hi <= w_res_hi;
              r_zero      <= w_zero;
              r_lt        <= w_lt;
              r_dbz       <= 1'b0;
              r_ill       <= w_ill;
`ifdef ALU_OVERFLOW_EN
              r_ovf       <= w_ovf;
`endif
              r_state     <= S_DONE;
            end
          end
        end
        S_RUN: begin
          r_hi  <= w_hi_nxt;
          r_lo  <= w_lo_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_ITER) begin
            // product {hi,lo} and {remainder,quotient} share the same mapping
            r_result    <= w_lo_nxt;
            r_result_hi <= w_hi_nxt;
            r_zero      <= (w_lo_nxt == '0);
            r_lt        <= 1'b0;
            r_dbz       <= 1'b0;
            r_ill       <= 1'b0;
`ifdef ALU_OVERFLOW_EN
            r_ovf       <= 1'b0;
`endif
            r_state     <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed testbench for alu_exec_unit (WIDTH=16). Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_alu_exec_unit;

  localparam int W = 16;

  logic         clk;
  logic         reset;
  logic         start;
  logic [3:0]   operation;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         zero;
  logic         lt;
  logic         div_by_zero;
  logic         illegal_op;
`ifdef ALU_OVERFLOW_EN
  logic         ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  alu_exec_unit #(.WIDTH(W), .CNT_W(5)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .operation(operation),
    .op_a(op_a),
    .op_b(op_b),
    .busy(busy),
    .done(done),
    .result(result),
    .result_hi(result_hi),
    .zero(zero),
    .lt(lt),
    .div_by_zero(div_by_zero),
`ifdef ALU_OVERFLOW_EN
    .ovf(ovf),
`endif
    .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op and follow it until the unit is idle again.
  // lat: falling edges after the accepting rising edge until done (-1: never)
  // inj: falling-edge index at which a spurious start (add 1+1) is driven
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int inj, output int lat, output int bcnt, output int dcnt);
    lat = -1; bcnt = 0; dcnt = 0;
    @(negedge clk);
    start = 1'b1; operation = op; op_a = a; op_b = b;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == inj) begin
        start = 1'b1; operation = 4'b0001; op_a = 16'h0001; op_b = 16'h0001;
      end
      if (i == inj + 1) start = 1'b0;
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        if (lat < 0) lat = i;
      end
      if (!busy) break;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; operation = '0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL por_busy_done got=%b exp=00", {busy, done}); end
    n_cmp++; if ({result, result_hi} !== 32'h0) begin n_err++; $display("FAIL por_results got=%h exp=0", {result, result_hi}); end
    n_cmp++; if ({zero, lt, div_by_zero, illegal_op} !== 4'b0000) begin n_err++; $display("FAIL por_flags got=%b exp=0000", {zero, lt, div_by_zero, illegal_op}); end
`ifdef ALU_OVERFLOW_EN
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL por_ovf got=%b exp=0", ovf); end
`endif
  endtask

  task automatic test_add_sub;
    int lat, bc, dc;
    run_op(4'b0001, 16'hFFFF, 16'h0001, 0, lat, bc, dc);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL add_wrap_latency got=%0d exp=1", lat); end
    n_cmp++; if ({result, result_hi, zero} !== {16'h0000, 16'h0000, 1'b1}) begin n_err++; $display("FAIL add_wrap got=%h/%h z=%b exp=0000/0000 z=1", result, result_hi, zero); end
    run_op(4'b0010, 16'h0005, 16'h0007, 0, lat, bc, dc);
    n_cmp++; if ({result, zero, lt} !== {16'hFFFE, 1'b0, 1'b0}) begin n_err++; $display("FAIL sub got=%h z=%b lt=%b exp=fffe z=0 lt=0", result, zero, lt); end
`ifdef ALU_OVERFLOW_EN
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL sub_no_ovf got=%b exp=0", ovf); end
    run_op(4'b0001, 16'h7FFF, 16'h0001, 0, lat, bc, dc);
    n_cmp++; if ({result, ovf} !== {16'h8000, 1'b1}) begin n_err++; $display("FAIL add_ovf got=%h ovf=%b exp=8000 ovf=1", result, ovf); end
    run_op(4'b0010, 16'h8000, 16'h0001, 0, lat, bc, dc);
    n_cmp++; if ({result, ovf} !== {16'h7FFF, 1'b1}) begin n_err++; $display("FAIL sub_ovf got=%h ovf=%b exp=7fff ovf=1", result, ovf); end
    run_op(4'b0111, 16'hFFFF, 16'hFFFF, 0, lat, bc, dc);
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL and_ovf_clear got=%b exp=0", ovf); end
`endif
  endtask

  task automatic test_logic;
    int lat, bc, dc;
    run_op(4'b0111, 16'hF0F0, 16'hFF00, 0, lat, bc, dc);
    n_cmp++; if (result !== 16'hF000) begin n_err++; $display("FAIL and got=%h exp=f000", result); end
    run_op(4'b1000, 16'hF0F0, 16'h0F0F, 0, lat, bc, dc);
    n_cmp++; if ({result, result_hi} !== {16'hFFFF, 16'h0000}) begin n_err++; $display("FAIL or got=%h/%h exp=ffff/0000", result, result_hi); end
    run_op(4'b0101, 16'h1234, 16'hABCD, 0, lat, bc, dc);
    n_cmp++; if ({result, result_hi} !== {16'hABCD, 16'h0000}) begin n_err++; $display("FAIL move got=%h/%h exp=abcd/0000", result, result_hi); end
    run_op(4'b0000, 16'h1234, 16'hABCD, 0, lat, bc, dc);
    n_cmp++; if ({result, zero, illegal_op} !== {16'h0000, 1'b1, 1'b0}) begin n_err++; $display("FAIL nop got=%h z=%b ill=%b exp=0000 z=1 ill=0", result, zero, illegal_op); end
  endtask

  task automatic test_mult;
    int lat, bc, dc;
    run_op(4'b0011, 16'h1234, 16'h0100, 5, lat, bc, dc);
    n_cmp++; if (lat !== 17) begin n_err++; $display("FAIL mult_latency got=%0d exp=17", lat); end
    n_cmp++; if (bc !== 17) begin n_err++; $display("FAIL mult_busy_cycles got=%0d exp=17", bc); end
    n_cmp++; if (dc !== 1) begin n_err++; $display("FAIL mult_done_pulses got=%0d exp=1", dc); end
    n_cmp++; if ({result_hi, result} !== 32'h0012_3400) begin n_err++; $display("FAIL mult got=%h_%h exp=0012_3400", result_hi, result); end
    run_op(4'b0011, 16'hFFFF, 16'hFFFF, 0, lat, bc, dc);
    n_cmp++; if ({result_hi, result, zero} !== {32'hFFFE_0001, 1'b0}) begin n_err++; $display("FAIL mult_max got=%h_%h z=%b exp=fffe_0001 z=0", result_hi, result, zero); end
  endtask

  task automatic test_div;
    int lat, bc, dc;
    run_op(4'b0100, 16'd100, 16'd0, 0, lat, bc, dc);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL div0_latency got=%0d exp=1", lat); end
    n_cmp++; if ({result, result_hi, div_by_zero} !== {16'hFFFF, 16'd100, 1'b1}) begin n_err++; $display("FAIL div0 got=%h/%h dbz=%b exp=ffff/0064 dbz=1", result, result_hi, div_by_zero); end
    run_op(4'b0100, 16'd100, 16'd7, 0, lat, bc, dc);
    n_cmp++; if (lat !== 17) begin n_err++; $display("FAIL div_latency got=%0d exp=17", lat); end
    n_cmp++; if ({result, result_hi, div_by_zero} !== {16'd14, 16'd2, 1'b0}) begin n_err++; $display("FAIL div got=%0d/%0d dbz=%b exp=14/2 dbz=0", result, result_hi, div_by_zero); end
    run_op(4'b0100, 16'hFFFF, 16'h0010, 0, lat, bc, dc);
    n_cmp++; if ({result, result_hi} !== {16'h0FFF, 16'h000F}) begin n_err++; $display("FAIL div_big got=%h/%h exp=0fff/000f", result, result_hi); end
  endtask

  task automatic test_compare;
    int lat, bc, dc;
    run_op(4'b1001, 16'hFFFE, 16'h0003, 0, lat, bc, dc);
    n_cmp++; if ({result, zero, lt} !== {16'h0000, 1'b0, 1'b1}) begin n_err++; $display("FAIL cmp_lt got=%h z=%b lt=%b exp=0000 z=0 lt=1", result, zero, lt); end
    run_op(4'b1001, 16'h00AA, 16'h00AA, 0, lat, bc, dc);
    n_cmp++; if ({result, zero, lt} !== {16'h0000, 1'b1, 1'b0}) begin n_err++; $display("FAIL cmp_eq got=%h z=%b lt=%b exp=0000 z=1 lt=0", result, zero, lt); end
    run_op(4'b1001, 16'h0003, 16'hFFFE, 0, lat, bc, dc);
    n_cmp++; if ({zero, lt} !== 2'b00) begin n_err++; $display("FAIL cmp_gt got=z%b lt%b exp=z0 lt0", zero, lt); end
  endtask

  task automatic test_swap_illegal;
    int lat, bc, dc;
    run_op(4'b1100, 16'h1234, 16'h5678, 0, lat, bc, dc);
    n_cmp++; if ({lat, dc} !== {32'd1, 32'd1}) begin n_err++; $display("FAIL illegal_done got lat=%0d pulses=%0d exp lat=1 pulses=1", lat, dc); end
    n_cmp++; if ({result, result_hi, illegal_op} !== {16'h0000, 16'h0000, 1'b1}) begin n_err++; $display("FAIL illegal got=%h/%h ill=%b exp=0000/0000 ill=1", result, result_hi, illegal_op); end
    run_op(4'b0110, 16'h1111, 16'h2222, 0, lat, bc, dc);
    n_cmp++; if ({result, result_hi, illegal_op} !== {16'h2222, 16'h1111, 1'b0}) begin n_err++; $display("FAIL swap got=%h/%h ill=%b exp=2222/1111 ill=0", result, result_hi, illegal_op); end
  endtask

  task automatic test_reset_mid_mult;
    int dcnt;
    int lat, bc, dc;
    dcnt = 0;
    @(negedge clk);
    start = 1'b1; operation = 4'b0011; op_a = 16'h1234; op_b = 16'h0100;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_mult_busy got=%b exp=1", busy); end
    reset = 1'b0;
    #1;
    n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL abort_busy_done got=%b exp=00", {busy, done}); end
    n_cmp++; if ({result, result_hi, zero, lt, div_by_zero, illegal_op} !== 36'h0) begin n_err++; $display("FAIL abort_outputs got=%h/%h flags=%b exp=0", result, result_hi, {zero, lt, div_by_zero, illegal_op}); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    n_cmp++; if (dcnt !== 0) begin n_err++; $display("FAIL abort_no_done got=%0d active cycles exp=0", dcnt); end
    n_cmp++; if (result !== 16'h0000) begin n_err++; $display("FAIL abort_result_hold got=%h exp=0000", result); end
    run_op(4'b0001, 16'd5, 16'd7, 0, lat, bc, dc);
    n_cmp++; if ({lat, 16'h0, result} !== {32'd1, 16'h0, 16'd12}) begin n_err++; $display("FAIL post_reset_add got lat=%0d res=%0d exp lat=1 res=12", lat, result); end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_logic();
    test_mult();
    test_div();
    test_compare();
    test_swap_illegal();
    test_reset_mid_mult();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution unit that consumes the 4-bit `operation` code produced by the ALU control decoder and performs the operation on two register operands.
- Single-cycle ops: add, sub, move, swap, and, or, compare, nop.
- Multi-cycle ops: iterative shift-add multiply and restoring divide.
- Sits between the register-file read stage and writeback. The start/busy/done handshake lets the control FSM stall on mult/div.

Parameters:
- WIDTH, 16, operand and result width in bits (≥4).
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset (reset==0 resets)
- start  input  1  request; accepted only on a rising edge where busy==0
- operation  input  4  op code, sampled with start
- op_a  input  WIDTH  operand A, sampled with start
- op_b  input  WIDTH  operand B, sampled with start
- busy  output  1  unit is occupied (state != IDLE)
- done  output  1  one-cycle pulse; result outputs valid
- result  output  WIDTH  primary result
- result_hi  output  WIDTH  product high half / remainder / swap second word
- zero  output  1  compare: A==B; other ops: result==0
- lt  output  1  compare only: signed A<B; otherwise 0
- div_by_zero  output  1  valid with done for divide
- illegal_op  output  1  valid with done for an unknown code

Behaviour:
- Reset (async, active-low):
  - state=IDLE, counter=0.
  - All outputs 0.
  - Any in-flight op is aborted with no done pulse.
- Op codes and results:
  - 0000 nop: result=0.
  - 0001 add: A+B mod 2^WIDTH.
  - 0010 sub: A−B mod 2^WIDTH.
  - 0011 mult: unsigned; {result_hi,result}=A*B (2·WIDTH bits).
  - 0100 div: unsigned; result=A/B, result_hi=A%B.
  - 0101 move: result=B.
  - 0110 swap: result=B, result_hi=A.
  - 0111 and: A&B.
  - 1000 or: A|B.
  - 1001 compare: result=0, zero=(A==B), lt=signed(A)<signed(B).
  - 1010–1111: treated as nop with illegal_op=1.
  - For every op other than mult, div and swap, result_hi=0.
- FSM states IDLE, RUN, DONE; busy = (state != IDLE).
  - IDLE + start → single-cycle op: compute and register outputs, go to DONE.
  - IDLE + start → mult: latch operands, clear accumulator, counter=0, go to RUN.
  - IDLE + start → div with B≠0: same as mult.
  - IDLE + start → div with B==0: go straight to DONE with result=all ones, result_hi=A, div_by_zero=1.
  - RUN: one shift-add or restore-subtract iteration per clock, counter++. After WIDTH iterations, write final values to the outputs and go to DONE.
  - DONE: done=1 for exactly this cycle, then go to IDLE.
- Latency, with start sampled at edge E:
  - Single-cycle ops: done high in the cycle after E.
  - mult/div: done high in the cycle after edge E+WIDTH.
  - Throughput: at most one accepted op per 2 cycles.
- start while busy==1 is ignored; the op is not queued. operation/op_a/op_b changes during RUN have no effect.
- result, result_hi, zero, lt, div_by_zero and illegal_op:
  - hold their values from the last completed op until the next op reaches DONE;
  - must not show intermediate RUN values;
  - div_by_zero and illegal_op are cleared on each new completion unless they apply.

Optional Feature:
- Macro: ALU_OVERFLOW_EN.
- When defined:
  - Adds output port `ovf` (1 bit).
  - For add/sub, `ovf` = signed two's-complement overflow, valid with done.
  - For all other ops `ovf`=0.
  - Reset value 0; holds like the other result outputs.
- When undefined: no `ovf` port and no overflow logic.

Test Plan (WIDTH=16):
- Reset low mid-mult (3 cycles into RUN), then release → busy=0, done never pulses, all outputs 0; a new add 5+7 then gives result=12, done one cycle after start.
- add 0xFFFF+0x0001 → result=0x0000, zero=1, done 1 cycle later. With ALU_OVERFLOW_EN, add 0x7FFF+0x0001 → ovf=1.
- mult 0x1234*0x0100 → result=0x3400, result_hi=0x0012. busy high for 17 cycles; done exactly in the cycle after edge E+16. A start pulse issued mid-RUN is ignored.
- div 100/7 → result=14, result_hi=2. div 100/0 → done in the cycle after E, result=0xFFFF, result_hi=100, div_by_zero=1.
- compare A=0xFFFE(−2), B=0x0003 → lt=1, zero=0, result=0. Compare A=B=0x00AA → zero=1, lt=0.
- swap A=0x1111, B=0x2222 → result=0x2222, result_hi=0x1111. operation=1100 → illegal_op=1, result=0, done pulses.
